gate_sweep_checker: RTL and testbench

//   Synthesisable exhaustive truth-table checker for N-input combinational gates. Walks every

---
 rtl/gate_sweep_if.sv | 29 ++
 rtl/gate_sweep_checker.sv | 116 +++++++++++
 tb/tb_gate_sweep_checker.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_if.sv
// rtl/gate_sweep_if.sv - control, status and DUT-facing signals of gate_sweep_checker
// GATE_SWEEP_FAILLOG_EN adds the first-fail capture signals.
interface gate_sweep_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
);
    logic             start;
    logic [2:0]       op;
    logic [N_IN-1:0]  stim;
    logic             resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
`ifdef GATE_SWEEP_FAILLOG_EN
    logic             first_fail_vld;
    logic [N_IN-1:0]  first_fail_vec;

    modport master (output start, op, resp,
                    input  stim, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec);
    modport slave  (input  start, op, resp,
                    output stim, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec);
`else
    modport master (output start, op, resp,
                    input  stim, busy, done, pass, err_cnt);
    modport slave  (input  start, op, resp,
                    output stim, busy, done, pass, err_cnt);
`endif
endinterface

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive truth-table sweep checker for an N-input gate
// Optional first-fail capture enabled by defining GATE_SWEEP_FAILLOG_EN.
module gate_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    gate_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [7:0] SETTLE_L = 8'(SETTLE);

    state_t           state, state_nxt;
    logic [N_IN-1:0]  stim_q;
    logic [7:0]       cnt_q;
    logic [2:0]       op_q;
    logic [ERR_W-1:0] err_q, err_inc;
    logic             pass_q;
    logic             expected, mismatch, last_vec, legal;

    always_comb begin
        expected = 1'b0;
        case (op_q)
            3'd0: expected =  &stim_q;
            3'd1: expected =  |stim_q;
            3'd2: expected = ~&stim_q;
            3'd3: expected = ~|stim_q;
            3'd4: expected =  ^stim_q;
            3'd5: expected = ~^stim_q;
            default: expected = 1'b0;
        endcase
    end

    assign legal    = (bus.op <= 3'd5);
    assign last_vec = &stim_q;
    assign mismatch = (state == SAMPLE) && (bus.resp != expected);
    // Counter saturates so a heavily broken gate cannot wrap back to a clean-looking value.
    assign err_inc  = (mismatch && (err_q != {ERR_W{1'b1}})) ? err_q + 1'b1 : err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = legal ? DRIVE : DONE;
            DRIVE:   if (cnt_q == 8'd0) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q <= '0;
            cnt_q  <= 8'd0;
            op_q   <= 3'd0;
            err_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    stim_q <= '0;
                    cnt_q  <= SETTLE_L;
                    op_q   <= bus.op;
                    err_q  <= '0;
                    pass_q <= 1'b0;
                end
                DRIVE: if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
                SAMPLE: begin
                    err_q <= err_inc;
                    if (last_vec) begin
                        pass_q <= (err_inc == '0);
                    end else begin
                        stim_q <= stim_q + 1'b1;
                        cnt_q  <= SETTLE_L;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_SWEEP_FAILLOG_EN
    logic            ff_vld;
    logic [N_IN-1:0] ff_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vld <= 1'b0;
            ff_vec <= '0;
        end else if (state == IDLE && bus.start) begin
            ff_vld <= 1'b0;
            ff_vec <= '0;
        end else if (mismatch && !ff_vld) begin
            ff_vld <= 1'b1;
            ff_vec <= stim_q;
        end
    end

    assign bus.first_fail_vld = ff_vld;
    assign bus.first_fail_vec = ff_vec;
`endif

    assign bus.stim    = stim_q;
    assign bus.busy    = (state == DRIVE) || (state == SAMPLE);
    assign bus.done    = (state == DONE);
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - table-driven scoreboard bench for gate_sweep_checker
module tb_gate_sweep_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    gate_sweep_if #(.N_IN(2), .ERR_W(8)) ifa ();
    gate_sweep_if #(.N_IN(4), .ERR_W(3)) ifb ();
    gate_sweep_if #(.N_IN(3), .ERR_W(8)) ifc ();

    gate_sweep_checker #(.N_IN(2), .SETTLE(1), .ERR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    gate_sweep_checker #(.N_IN(4), .SETTLE(0), .ERR_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    gate_sweep_checker #(.N_IN(3), .SETTLE(2), .ERR_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // Gate-under-test model: gate function plus fault (0 none, 1 stuck-1, 2 stuck-0, 3 invert on mask).
    int gate_a = 0, fault_a = 0, mask_a = 0;
    int gate_b = 0, fault_b = 0, mask_b = 0;
    int gate_c = 0, fault_c = 0, mask_c = 0;

    function automatic logic ref_gate(int op, int v, int n);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += (v >> i) & 1;
        case (op)
            0: return ones == n;
            1: return ones != 0;
            2: return ones != n;
            3: return ones == 0;
            4: return ones[0];
            5: return !ones[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_resp(int gate, int fault, int mask, int v, int n);
        logic r = ref_gate(gate, v, n);
        if (fault == 1) return 1'b1;
        if (fault == 2) return 1'b0;
        if (fault == 3 && mask[v]) return !r;
        return r;
    endfunction

    function automatic int exp_err(int op, int gate, int fault, int mask, int n, int errw);
        int c = 0;
        if (op > 5) return 0;
        for (int v = 0; v < (1 << n); v++)
            if (ref_gate(op, v, n) != model_resp(gate, fault, mask, v, n)) c++;
        return (c > (1 << errw) - 1) ? (1 << errw) - 1 : c;
    endfunction

    always_comb ifa.resp = model_resp(gate_a, fault_a, mask_a, int'(ifa.stim), 2);
    always_comb ifb.resp = model_resp(gate_b, fault_b, mask_b, int'(ifb.stim), 4);
    always_comb ifc.resp = model_resp(gate_c, fault_c, mask_c, int'(ifc.stim), 3);

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct { int pass; int err; int due; } sb_t;
    sb_t qa[$], qb[$], qc[$];

    task automatic chk_done(string tag, int pass, int err, int busy, sb_t e);
        chk({tag, "_pass"}, pass, e.pass);
        chk({tag, "_err_cnt"}, err, e.err);
        chk({tag, "_latency"}, cyc, e.due);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    always @(negedge clk) if (rst_n && ifa.done) begin
        sb_t e;
        if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin e = qa.pop_front(); chk_done("a", int'(ifa.pass), int'(ifa.err_cnt), int'(ifa.busy), e); end
    end
    always @(negedge clk) if (rst_n && ifb.done) begin
        sb_t e;
        if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
        else begin e = qb.pop_front(); chk_done("b", int'(ifb.pass), int'(ifb.err_cnt), int'(ifb.busy), e); end
    end
    always @(negedge clk) if (rst_n && ifc.done) begin
        sb_t e;
        if (qc.size() == 0) chk("c_unexpected_done", 1, 0);
        else begin e = qc.pop_front(); chk_done("c", int'(ifc.pass), int'(ifc.err_cnt), int'(ifc.busy), e); end
    end

    // Stimulus ordering on dut_a: starts at 0, then steps by exactly one per change.
    logic [1:0] prev_stim = 2'd0;
    logic       prev_busy = 1'b0;
    always @(negedge clk) begin
        if (ifa.busy) begin
            if (!prev_busy) chk("a_stim_first", int'(ifa.stim), 0);
            else if (ifa.stim != prev_stim) chk("a_stim_step", int'(ifa.stim), int'(prev_stim) + 1);
        end
        prev_stim <= ifa.stim;
        prev_busy <= ifa.busy;
    end

    function automatic int qsize(int d);
        case (d)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic wait_q(int d);
        for (int i = 0; i < 500; i++) begin
            if (qsize(d) == 0) break;
            @(negedge clk); #1;
        end
        if (qsize(d) != 0) begin
            chk("done_timeout", 0, 1);
            case (d) 0: qa.delete(); 1: qb.delete(); default: qc.delete(); endcase
        end
    endtask

    task automatic set_start(int d, logic s, int op_v);
        case (d)
            0: begin ifa.start = s; ifa.op = op_v[2:0]; end
            1: begin ifb.start = s; ifb.op = op_v[2:0]; end
            default: begin ifc.start = s; ifc.op = op_v[2:0]; end
        endcase
    endtask

    // lat counts edges after the accepting edge; 0 means done in the very next cycle.
    task automatic run(int d, int op_v, int ps, int er, int lat);
        sb_t e;
        @(negedge clk);
        set_start(d, 1'b1, op_v);
        e.pass = ps; e.err = er; e.due = cyc + 1 + lat;
        case (d) 0: qa.push_back(e); 1: qb.push_back(e); default: qc.push_back(e); endcase
        @(negedge clk);
        set_start(d, 1'b0, op_v);
        if (lat == 0 && d == 0) chk("a_busy_illegal_op", int'(ifa.busy), 0);
        wait_q(d);
    endtask

    typedef struct { int op; int gate; int fault; int pass; int err; } vec_t;
    vec_t tbl[9];

    initial begin
        sb_t e;
        tbl[0] = '{2, 2, 0, 1, 0};
        tbl[1] = '{2, 2, 1, 0, 1};
        tbl[2] = '{0, 0, 0, 1, 0};
        tbl[3] = '{1, 0, 0, 0, 2};
        tbl[4] = '{4, 4, 0, 1, 0};
        tbl[5] = '{5, 4, 0, 0, 4};
        tbl[6] = '{3, 3, 2, 0, 1};
        tbl[7] = '{6, 0, 0, 0, 0};
        tbl[8] = '{7, 2, 1, 0, 0};

        set_start(0, 1'b0, 0); set_start(1, 1'b0, 0); set_start(2, 1'b0, 0);
        #1;
        chk("rst_stim", int'(ifa.stim), 0);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_done", int'(ifa.done), 0);
        chk("rst_pass", int'(ifa.pass), 0);
        chk("rst_err_cnt", int'(ifa.err_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            gate_a = tbl[i].gate; fault_a = tbl[i].fault; mask_a = 0;
            run(0, tbl[i].op, tbl[i].pass, tbl[i].err, (tbl[i].op <= 5) ? 12 : 0);
        end

        // start/op changes while busy are ignored
        gate_a = 2; fault_a = 0;
        @(negedge clk);
        set_start(0, 1'b1, 2);
        e.pass = 1; e.err = 0; e.due = cyc + 1 + 12; qa.push_back(e);
        @(negedge clk); set_start(0, 1'b0, 2);
        repeat (3) @(negedge clk);
        set_start(0, 1'b1, 7);
        @(negedge clk); set_start(0, 1'b0, 7);
        wait_q(0);

        // back-to-back: start held through DONE is taken in the following IDLE cycle
        @(negedge clk);
        set_start(0, 1'b1, 2);
        e.pass = 1; e.err = 0; e.due = cyc + 1 + 12; qa.push_back(e);
        @(negedge clk); set_start(0, 1'b0, 2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifa.done) break;
        end
        set_start(0, 1'b1, 3);
        e.pass = 0; e.err = 2; e.due = cyc + 2 + 12; qa.push_back(e);
        @(negedge clk); @(negedge clk);
        set_start(0, 1'b0, 3);
        wait_q(0);

        // asynchronous reset mid-sweep, then a full sweep
        gate_a = 1; fault_a = 2;
        @(negedge clk); set_start(0, 1'b1, 1);
        @(negedge clk); set_start(0, 1'b0, 1);
        for (int i = 0; i < 100; i++) begin
            if (ifa.busy && ifa.stim == 2'd2) break;
            @(negedge clk);
        end
        chk("pre_rst_err_cnt", int'(ifa.err_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_stim", int'(ifa.stim), 0);
        chk("async_rst_busy", int'(ifa.busy), 0);
        chk("async_rst_err_cnt", int'(ifa.err_cnt), 0);
        @(negedge clk); rst_n = 1'b1;
        run(0, 1, 0, 3, 12);

        // wide sweep with a narrow saturating counter
        gate_b = 0; fault_b = 2;
        run(1, 1, 0, exp_err(1, 0, 2, 0, 4, 3), 32);
        gate_b = 0; fault_b = 1;
        run(1, 0, 0, exp_err(0, 0, 1, 0, 4, 3), 32);
        gate_b = 4; fault_b = 0;
        run(1, 4, 1, exp_err(4, 4, 0, 0, 4, 3), 32);

        // XOR gate with faults on vectors 5 and 7
        gate_c = 4; fault_c = 3; mask_c = (1 << 5) | (1 << 7);
        run(2, 4, 0, exp_err(4, 4, 3, mask_c, 3, 8), 32);
`ifdef GATE_SWEEP_FAILLOG_EN
        chk("c_first_fail_vld", int'(ifc.first_fail_vld), 1);
        chk("c_first_fail_vec", int'(ifc.first_fail_vec), 5);
`endif
        fault_c = 0;
        run(2, 4, 1, 0, 32);
`ifdef GATE_SWEEP_FAILLOG_EN
        chk("c_first_fail_cleared", int'(ifc.first_fail_vld), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
